// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: merges FP arithmetic results (port A) and FP load results
// (port B) into a small in-order queue. The queue drains one entry per cycle
// through the FP register file write port. A pending-write mask over the
// queued destinations lets decode detect RAW hazards against queued writes.
module fp_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [AW-1:0]          a_rd,
  input  logic [WIDTH-1:0]       a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [AW-1:0]          b_rd,
  input  logic [WIDTH-1:0]       b_data,
  output logic                   regWr,
  output logic [AW-1:0]          rW,
  output logic [WIDTH-1:0]       busW,
  output logic [31:0]            pend,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;

  logic [AW-1:0]    r_rdMem   [DEPTH];
  logic [WIDTH-1:0] r_dataMem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;

  logic             w_deq;
  logic [CW-1:0]    w_space;
  logic [CW-1:0]    w_bNeed;
  logic             w_aPush;
  logic             w_bPush;
  logic [PW-1:0]    w_bIdx;
  logic [CW-1:0]    w_countNext;
  logic [CW1-1:0]   w_countWide;
  logic [PW-1:0]    w_slotOff  [DEPTH];
  logic             w_occupied [DEPTH];

  // The register file always accepts, so a non-empty queue dequeues its head
  // on every edge. That dequeue frees a slot the same cycle, and the free-slot
  // count includes it.
  assign w_deq   = (r_count != '0);
  assign w_space = CW'(DEPTH) - r_count + CW'(w_deq);

  // A has priority. A dropped rd==0 beat takes no slot, so it does not raise
  // B's requirement. b_ready therefore depends combinationally on a_valid.
  assign a_ready = reset && !flush && (w_space >= CW'(1));
  assign w_aPush = a_valid && a_ready && (a_rd != '0);
  assign w_bNeed = w_aPush ? CW'(2) : CW'(1);
  assign b_ready = reset && !flush && (w_space >= w_bNeed);
  assign w_bPush = b_valid && b_ready && (b_rd != '0);

  // On a double push, B lands in the slot after A (the younger slot).
  assign w_bIdx      = r_wrPtr + PW'(w_aPush);
  assign w_countNext = r_count - CW'(w_deq) + CW'(w_aPush) + CW'(w_bPush);
  assign w_countWide = {1'b0, r_count} - CW1'(w_deq) + CW1'(w_aPush) + CW1'(w_bPush);

  // A slot is live when its distance from the head is below the occupancy.
  // DEPTH is a power of two, so the subtraction wraps for free.
  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : gSlot
      assign w_slotOff[g]  = PW'(g) - r_rdPtr;
      assign w_occupied[g] = ({1'b0, w_slotOff[g]} < r_count);
    end
  endgenerate

  // Queue bookkeeping. Flush discards everything still queued. The head that
  // is already on the write port that cycle still reaches the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      r_rdPtr <= r_rdPtr + PW'(w_deq);
      r_wrPtr <= r_wrPtr + PW'(w_aPush) + PW'(w_bPush);
      r_count <= w_countNext;
    end
  end

  // Entry storage. Validity comes only from the pointers and the count, so
  // the payload needs no reset.
  always_ff @(posedge clk) begin
    if (w_aPush) begin
      r_rdMem[r_wrPtr]   <= a_rd;
      r_dataMem[r_wrPtr] <= a_data;
    end
    if (w_bPush) begin
      r_rdMem[w_bIdx]   <= b_rd;
      r_dataMem[w_bIdx] <= b_data;
    end
  end

  // The write port shows the head entry and is forced to zero when empty.
  always_comb begin
    regWr = w_deq;
    rW    = '0;
    busW  = '0;
    if (w_deq) begin
      rW   = r_rdMem[r_rdPtr];
      busW = r_dataMem[r_rdPtr];
    end
  end

  // Pending mask: one bit per register that has any write still queued.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_occupied[i]) begin
        pend[r_rdMem[i]] = 1'b1;
      end
    end
    pend[0] = 1'b0;
  end

  assign count = r_count;

  // The handshake rules must keep occupancy within 0..DEPTH.
  assert property (@(posedge clk) disable iff (!reset) w_countWide <= CW1'(DEPTH));
  assert property (@(posedge clk) disable iff (!reset) r_count <= CW'(DEPTH));

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed and random stimulus for fp_wb_arbiter. A queue
// model is updated once per clock edge and checked against the DUT every cycle.
module tb_fp_wb_arbiter;

  localparam int DEPTH = 4;
  localparam int WIDTH = 64;
  localparam int AW    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             aValid;
  logic             aReady;
  logic [AW-1:0]    aRd;
  logic [WIDTH-1:0] aData;
  logic             bValid;
  logic             bReady;
  logic [AW-1:0]    bRd;
  logic [WIDTH-1:0] bData;
  logic             regWr;
  logic [AW-1:0]    rW;
  logic [WIDTH-1:0] busW;
  logic [31:0]      pend;
  logic [$clog2(DEPTH):0] count;

  typedef struct packed {
    logic [AW-1:0]    rd;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t modelQ[$];
  int checks = 0;
  int errors = 0;

  fp_wb_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .a_valid(aValid), .a_ready(aReady), .a_rd(aRd), .a_data(aData),
    .b_valid(bValid), .b_ready(bReady), .b_rd(bRd), .b_data(bData),
    .regWr(regWr), .rW(rW), .busW(busW), .pend(pend), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelPend();
    logic [31:0] p;
    p = '0;
    foreach (modelQ[i]) p[modelQ[i].rd] = 1'b1;
    return p;
  endfunction

  // Compare the registered outputs with the model queue.
  task automatic checkModel();
    logic [AW-1:0]    expRw;
    logic [WIDTH-1:0] expBus;
    expRw  = '0;
    expBus = '0;
    if (modelQ.size() != 0) begin
      expRw  = modelQ[0].rd;
      expBus = modelQ[0].data;
    end
    checkOutput("regWr", 64'(regWr), 64'(modelQ.size() != 0));
    checkOutput("rW", 64'(rW), 64'(expRw));
    checkOutput("busW", busW, expBus);
    checkOutput("pend", 64'(pend), 64'(modelPend()));
    checkOutput("count", 64'(count), 64'(modelQ.size()));
  endtask

  // Drive one cycle of inputs, check outputs and readies before the edge,
  // then advance the model across the edge.
  task automatic applyStimulus(input logic aV, input logic [AW-1:0] aR, input logic [WIDTH-1:0] aD,
                               input logic bV, input logic [AW-1:0] bR, input logic [WIDTH-1:0] bD,
                               input logic fl);
    int   space;
    logic expA;
    logic expB;
    logic aPush;
    logic bPush;
    aValid = aV; aRd = aR; aData = aD;
    bValid = bV; bRd = bR; bData = bD;
    flush  = fl;
    #1;
    space = DEPTH - modelQ.size() + ((modelQ.size() != 0) ? 1 : 0);
    expA  = reset && !fl && (space >= 1);
    aPush = aV && expA && (aR != 0);
    expB  = reset && !fl && (space >= (aPush ? 2 : 1));
    bPush = bV && expB && (bR != 0);
    checkModel();
    checkOutput("a_ready", 64'(aReady), 64'(expA));
    checkOutput("b_ready", 64'(bReady), 64'(expB));
    @(posedge clk);
    if (modelQ.size() != 0) void'(modelQ.pop_front());
    if (fl) begin
      modelQ.delete();
    end else begin
      if (aPush) modelQ.push_back('{rd: aR, data: aD});
      if (bPush) modelQ.push_back('{rd: bR, data: bD});
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    reset = 1'b0; flush = 1'b0;
    aValid = 1'b0; aRd = '0; aData = '0;
    bValid = 1'b0; bRd = '0; bData = '0;

    // Reset state: readies low even with valid inputs.
    repeat (3) @(posedge clk);
    #1;
    aValid = 1'b1; bValid = 1'b1; aRd = 5'd1; bRd = 5'd2;
    #1;
    checkOutput("rst_a_ready", 64'(aReady), 64'(0));
    checkOutput("rst_b_ready", 64'(bReady), 64'(0));
    checkOutput("rst_regWr", 64'(regWr), 64'(0));
    checkOutput("rst_count", 64'(count), 64'(0));
    checkOutput("rst_pend", 64'(pend), 64'(0));
    aValid = 1'b0; bValid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("post_rst_a_ready", 64'(aReady), 64'(1));
    checkOutput("post_rst_b_ready", 64'(bReady), 64'(1));

    // Single A write to f3.
    applyStimulus(1'b1, 5'd3, 64'h3FF0000000000000, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_regWr", 64'(regWr), 64'(1));
    checkOutput("t1_rW", 64'(rW), 64'(3));
    checkOutput("t1_busW", busW, 64'h3FF0000000000000);
    checkOutput("t1_pend", 64'(pend), 64'h8);
    idle();
    checkOutput("t1_regWr_after", 64'(regWr), 64'(0));
    checkOutput("t1_pend_after", 64'(pend), 64'(0));

    // Simultaneous A and B into an empty queue.
    applyStimulus(1'b1, 5'd5, 64'h55, 1'b1, 5'd6, 64'h66, 1'b0);
    checkOutput("t2_count", 64'(count), 64'(2));
    checkOutput("t2_rW_first", 64'(rW), 64'(5));
    idle();
    checkOutput("t2_rW_second", 64'(rW), 64'(6));
    idle();

    // Both ports valid every cycle until the queue fills.
    repeat (3) applyStimulus(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                             1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 1'b0);
    checkOutput("t3_count_full", 64'(count), 64'(4));
    checkOutput("t3_a_ready_full", 64'(aReady), 64'(1));
    checkOutput("t3_b_ready_full", 64'(bReady), 64'(0));
    repeat (4) applyStimulus(1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom},
                             1'b1, 5'($urandom_range(1, 31)), {$urandom, $urandom}, 1'b0);
    repeat (5) idle();

    // rd==0 beat is accepted and dropped.
    applyStimulus(1'b1, 5'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0, '0, 1'b0);
    checkOutput("t4_count", 64'(count), 64'(0));
    checkOutput("t4_regWr", 64'(regWr), 64'(0));
    checkOutput("t4_pend", 64'(pend), 64'(0));

    // Two writes to f7 back to back.
    applyStimulus(1'b1, 5'd7, 64'd1, 1'b0, '0, '0, 1'b0);
    checkOutput("t5_busW_first", busW, 64'd1);
    checkOutput("t5_pend_first", 64'(pend), 64'h80);
    applyStimulus(1'b1, 5'd7, 64'd2, 1'b0, '0, '0, 1'b0);
    checkOutput("t5_busW_second", busW, 64'd2);
    checkOutput("t5_pend_second", 64'(pend), 64'h80);
    idle();
    checkOutput("t5_pend_clear", 64'(pend), 64'(0));

    // Flush with three entries queued.
    applyStimulus(1'b1, 5'd10, 64'hA, 1'b1, 5'd11, 64'hB, 1'b0);
    applyStimulus(1'b1, 5'd12, 64'hC, 1'b1, 5'd13, 64'hD, 1'b0);
    checkOutput("t6_count_pre", 64'(count), 64'(3));
    applyStimulus(1'b1, 5'd14, 64'hE, 1'b1, 5'd15, 64'hF, 1'b1);
    checkOutput("t6_count_post", 64'(count), 64'(0));
    checkOutput("t6_regWr_post", 64'(regWr), 64'(0));
    checkOutput("t6_pend_post", 64'(pend), 64'(0));

    // Asynchronous reset while draining.
    applyStimulus(1'b1, 5'd20, 64'h20, 1'b1, 5'd21, 64'h21, 1'b0);
    applyStimulus(1'b1, 5'd22, 64'h22, 1'b1, 5'd23, 64'h23, 1'b0);
    idle();
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t7_regWr", 64'(regWr), 64'(0));
    checkOutput("t7_count", 64'(count), 64'(0));
    checkOutput("t7_a_ready", 64'(aReady), 64'(0));
    modelQ.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      applyStimulus(($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), d1,
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), d2,
                    ($urandom_range(0, 24) == 0));
    end
    repeat (6) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
